quad_osc_bank: RTL and testbench

QUAD_OSC_BANK -- requirements
Module: quad_osc_bank

---
 rtl/osc_pkg.sv | 15 +
 rtl/osc_rotate.sv | 48 ++++
 rtl/quad_osc_bank.sv | 132 +++++++++++++
 tb/tb_quad_osc_bank.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared definitions for the quadrature oscillator bank: FSM encoding and
// the symmetric saturation limit used by the rotation datapath.
package osc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Largest magnitude a w-bit signed sample may take; -2^(w-1) is excluded
  // so positive and negative clipping are symmetric.
  function automatic longint sat_limit(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/osc_rotate.sv
// One step of the coupled-form (magic circle) oscillator with symmetric
// saturation and upward zero-crossing detection of sin. Purely combinational.
module osc_rotate
  import osc_pkg::*;
#(
  parameter int W    = 16,
  parameter int KW   = 8,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0]  cos_in,
  input  logic signed [W-1:0]  sin_in,
  input  logic        [KW-1:0] coef,
  output logic signed [W-1:0]  cos_out,
  output logic signed [W-1:0]  sin_out,
  output logic                 zc,
  output logic                 sat
);

  localparam int                PW     = W + KW + 1;
  localparam longint            LIM    = sat_limit(W);
  localparam logic signed [W:0] SAT_HI = LIM[W:0];
  localparam logic signed [W:0] SAT_LO = -SAT_HI;

  logic signed [KW:0] k_s;
  logic signed [W:0]  q_sin, q_cos;
  logic signed [W:0]  sum_sin, sum_cos;
  logic               hi_s, lo_s, hi_c, lo_c;

  assign k_s = {1'b0, coef};

  // The sin update uses the old cos; the cos update uses the already
  // saturated new sin, which keeps the recurrence stable.
  assign q_sin   = (W+1)'((PW'(cos_in) * PW'(k_s)) >>> FRAC);
  assign sum_sin = (W+1)'(sin_in) + q_sin;
  assign hi_s    = sum_sin > SAT_HI;
  assign lo_s    = sum_sin < SAT_LO;
  assign sin_out = hi_s ? SAT_HI[W-1:0] : (lo_s ? SAT_LO[W-1:0] : sum_sin[W-1:0]);

  assign q_cos   = (W+1)'((PW'(sin_out) * PW'(k_s)) >>> FRAC);
  assign sum_cos = (W+1)'(cos_in) - q_cos;
  assign hi_c    = sum_cos > SAT_HI;
  assign lo_c    = sum_cos < SAT_LO;
  assign cos_out = hi_c ? SAT_HI[W-1:0] : (lo_c ? SAT_LO[W-1:0] : sum_cos[W-1:0]);

  assign sat = hi_s | lo_s | hi_c | lo_c;
  assign zc  = sin_in[W-1] & ~sin_out[W-1];

endmodule

// File: rtl/quad_osc_bank.sv
// Bank of CH quadrature oscillators sharing one rotation datapath; enabled
// channels are serviced round-robin, one sample per IDLE/CALC/HOLD pass.
module quad_osc_bank
  import osc_pkg::*;
#(
  parameter int W       = 16,
  parameter int CH      = 4,
  parameter int KW      = 8,
  parameter int FRAC    = 8,
  parameter int AMP_RST = 29491
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [CH-1:0]            en_mask,
  input  logic                     cfg_we,
  input  logic [$clog2(CH)-1:0]    cfg_ch,
  input  logic [KW-1:0]            cfg_coef,
  input  logic signed [W-1:0]      cfg_amp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(CH)-1:0]    out_ch,
  output logic signed [W-1:0]      out_cos,
  output logic signed [W-1:0]      out_sin,
  output logic                     out_zc,
  output logic                     out_sat
);

  localparam int                CW       = $clog2(CH);
  localparam logic signed [W-1:0] AMP_INIT = AMP_RST[W-1:0];

  logic signed [W-1:0] cos_r  [CH];
  logic signed [W-1:0] sin_r  [CH];
  logic        [KW-1:0] coef_r [CH];

  logic [1:0]    state;
  logic [CW-1:0] ptr, sel, pick, sel_next;
  logic [CW:0]   idx;
  logic          found, kill, cfg_ok;
  logic signed [W-1:0] rot_cos, rot_sin;
  logic          rot_zc, rot_sat;

  // Cyclic priority search for the first enabled channel at or after ptr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < CH; i++) begin
      idx = {1'b0, ptr} + (CW+1)'(i);
      if (idx >= (CW+1)'(CH)) idx = idx - (CW+1)'(CH);
      if (!found && en_mask[idx[CW-1:0]]) begin
        pick  = idx[CW-1:0];
        found = 1'b1;
      end
    end
  end

  assign sel_next = (sel == CW'(CH - 1)) ? '0 : sel + 1'b1;
  assign cfg_ok   = cfg_we && (int'(cfg_ch) < CH);

  osc_rotate #(.W(W), .KW(KW), .FRAC(FRAC)) u_rot (
    .cos_in  (cos_r[sel]),
    .sin_in  (sin_r[sel]),
    .coef    (coef_r[sel]),
    .cos_out (rot_cos),
    .sin_out (rot_sin),
    .zc      (rot_zc),
    .sat     (rot_sat)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      sel       <= '0;
      kill      <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_cos   <= '0;
      out_sin   <= '0;
      out_zc    <= 1'b0;
      out_sat   <= 1'b0;
      // NOTE: the channel file is plain flops, not RAM, so each entry is reset to a defined value.
      for (int c = 0; c < CH; c++) begin
        cos_r[c]  <= AMP_INIT;
        sin_r[c]  <= '0;
        coef_r[c] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (|en_mask) begin
            sel   <= pick;
            kill  <= 1'b0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          out_ch    <= sel;
          out_cos   <= rot_cos;
          out_sin   <= rot_sin;
          out_zc    <= rot_zc;
          out_sat   <= rot_sat;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (!kill) begin
              cos_r[sel] <= out_cos;
              sin_r[sel] <= out_sin;
            end
            ptr       <= sel_next;
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Configuration comes last so it overrides a same-cycle write-back.
      if (cfg_ok) begin
        coef_r[cfg_ch] <= cfg_coef;
        cos_r[cfg_ch]  <= cfg_amp;
        sin_r[cfg_ch]  <= '0;
        if (state != ST_IDLE && cfg_ch == sel) kill <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_osc_bank.sv
// Scoreboard bench for quad_osc_bank: stimulus pushes hand-computed samples,
// a negedge monitor compares every presented sample against the queue head.
module tb_quad_osc_bank;

  logic              clk = 1'b0;
  logic              rstb;
  logic [3:0]        en_mask;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [7:0]        cfg_coef;
  logic signed [15:0] cfg_amp;
  logic              out_valid, out_ready;
  logic [1:0]        out_ch;
  logic signed [15:0] out_cos, out_sin;
  logic              out_zc, out_sat;

  typedef struct {
    integer ch;
    integer c;
    integer s;
    integer zc;
    integer sat;
    bit     data;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e;
  int     n_vec = 0;
  int     n_bad = 0;
  int     zc_cnt = 0;

  always #5 clk = ~clk;

  quad_osc_bank #(.W(16), .CH(4), .KW(8), .FRAC(8), .AMP_RST(29491)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en_mask   (en_mask),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_coef  (cfg_coef),
    .cfg_amp   (cfg_amp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_cos   (out_cos),
    .out_sin   (out_sin),
    .out_zc    (out_zc),
    .out_sat   (out_sat)
  );

  task automatic check(input string nm, input integer act, input integer req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push(input integer ch, input integer c, input integer s,
                      input integer zc, input integer sat, input bit data);
    exp_t x;
    x.ch = ch; x.c = c; x.s = s; x.zc = zc; x.sat = sat; x.data = data;
    exp_q.push_back(x);
  endtask

  // Monitor: every cycle a sample is presented it must match the queue head;
  // the head is retired only when the handshake completes.
  always @(negedge clk) begin
    if (!rstb && out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_sample: got ch=%0d cos=%0d sin=%0d, required none", out_ch, out_cos, out_sin);
      end else begin
        e = exp_q[0];
        if (out_ch !== e.ch[1:0] ||
            (e.data && (out_cos !== e.c || out_sin !== e.s ||
                        out_zc !== e.zc[0] || out_sat !== e.sat[0]))) begin
          n_bad++;
          $display("FAIL sample: got ch=%0d cos=%0d sin=%0d zc=%0d sat=%0d, required ch=%0d cos=%0d sin=%0d zc=%0d sat=%0d",
                   out_ch, out_cos, out_sin, out_zc, out_sat, e.ch, e.c, e.s, e.zc, e.sat);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
      if (out_ready && out_zc && out_ch == 2'd0) zc_cnt++;
    end
  end

  task automatic do_reset();
    rstb = 1'b1; en_mask = '0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    check("rst_valid", out_valid, 0);
    check("rst_ch",    out_ch,    0);
    check("rst_cos",   out_cos,   0);
    check("rst_sin",   out_sin,   0);
    check("rst_zc",    out_zc,    0);
    check("rst_sat",   out_sat,   0);
    rstb = 1'b0;
  endtask

  task automatic cfg(input int ch, input int k, input int amp);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_coef = 8'(k); cfg_amp = 16'(amp);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < budget);
    check("wait_valid", out_valid, 1);
  endtask

  // Enable mask, collect n handshakes, drop the mask before the next IDLE.
  task automatic run(input logic [3:0] mask, input int n, input bit chk_rate);
    int got = 0;
    int cyc = 0;
    int last = -1;
    en_mask = mask;
    while (got < n && cyc < n * 3 + 20) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        got++;
        if (chk_rate && last >= 0) check("sample_spacing", cyc - last, 3);
        last = cyc;
        if (got == n) en_mask = '0;
      end
    end
    check("handshakes", got, n);
    en_mask = '0;
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rstb = 1'b1; en_mask = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_coef = '0; cfg_amp = '0; out_ready = 1'b1;

    // Reset state, coef=0 holds cos=29491 sin=0 constant.
    do_reset();
    push(0, 29491, 0, 0, 0, 1);
    push(0, 29491, 0, 0, 0, 1);
    run(4'b0001, 2, 1'b1);

    // Basic rotation, coef=16 amp=16384.
    do_reset();
    cfg(0, 16, 16384);
    push(0, 16320, 1024, 0, 0, 1);
    push(0, 16193, 2044, 0, 0, 1);
    push(0, 16002, 3056, 0, 0, 1);
    run(4'b0001, 3, 1'b1);

    // Round-robin over all four channels, wrapping back to ch0.
    do_reset();
    for (int c = 0; c < 4; c++) cfg(c, 16, 16384);
    for (int c = 0; c < 4; c++) push(c, 16320, 1024, 0, 0, 1);
    push(0, 16193, 2044, 0, 0, 1);
    run(4'b1111, 5, 1'b1);

    // Positive saturation on the second step.
    do_reset();
    cfg(0, 255, 32767);
    push(0, 256, 32639, 0, 0, 1);
    push(0, -32383, 32767, 0, 1, 1);
    run(4'b0001, 2, 1'b1);

    // Negative clip: -32768 becomes -32767 even with coef=0.
    do_reset();
    cfg(0, 0, -32768);
    push(0, -32767, 0, 0, 1, 1);
    run(4'b0001, 1, 1'b0);

    // Stall 10+ cycles in HOLD with the enable dropped; no early write-back.
    do_reset();
    cfg(0, 16, 16384);
    out_ready = 1'b0;
    push(0, 16320, 1024, 0, 0, 1);
    push(0, 16193, 2044, 0, 0, 1);
    en_mask = 4'b0001;
    wait_valid(10);
    en_mask = '0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    run(4'b0001, 2, 1'b0);

    // Reconfigure ch0 while its sample is held: delivered, write-back dropped.
    do_reset();
    cfg(0, 16, 16384);
    out_ready = 1'b0;
    push(0, 16320, 1024, 0, 0, 1);
    push(0, 8160, 512, 0, 0, 1);
    en_mask = 4'b0001;
    wait_valid(10);
    en_mask = '0;
    @(posedge clk); #1;
    cfg(0, 16, 8192);
    out_ready = 1'b1;
    run(4'b0001, 2, 1'b0);

    // One period (~100.5 steps) at coef=16: exactly one upward crossing in 120.
    do_reset();
    cfg(0, 16, 16384);
    zc_cnt = 0;
    push(0, 16320, 1024, 0, 0, 1);
    push(0, 16193, 2044, 0, 0, 1);
    push(0, 16002, 3056, 0, 0, 1);
    for (int i = 0; i < 117; i++) push(0, 0, 0, 0, 0, 0);
    run(4'b0001, 120, 1'b1);
    check("zc_count", zc_cnt, 1);

    // Reset during HOLD beats a same-cycle handshake and config write.
    do_reset();
    out_ready = 1'b0;
    push(0, 29491, 0, 0, 0, 1);
    en_mask = 4'b0001;
    wait_valid(10);
    @(posedge clk); #1;
    rstb = 1'b1; out_ready = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_coef = 8'd16; cfg_amp = 16'sd5000;
    @(posedge clk); #1;
    check("valid_after_rst", out_valid, 0);
    check("cos_after_rst",   out_cos,   0);
    exp_q.delete();
    rstb = 1'b0; cfg_we = 1'b0; en_mask = '0;
    push(0, 29491, 0, 0, 0, 1);
    run(4'b0001, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
